// File: rtl/sound_pkg.sv
// sound_pkg: shared note divisor constants, song ROM field layout and sequencer states
package sound_pkg;

    localparam int NOTE_DIV_W = 20;

    localparam int REST_BIT = 7;
    localparam int IDX_HI   = 6;
    localparam int IDX_LO   = 3;
    localparam int DUR_HI   = 2;
    localparam int DUR_LO   = 0;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOAD,
        HOLD
    } state_t;

    localparam logic [NOTE_DIV_W-1:0] NOTE_DIVS [16] = '{
        20'd76628,  20'd68259,  20'd60606,  20'd57306,
        20'd51020,  20'd45454,  20'd40485,  20'd153256,
        20'd136518, 20'd121212, 20'd114613, 20'd102040,
        20'd90909,  20'd80971,  20'd181818, 20'd163265
    };

endpackage

// File: rtl/note_div_lut.sv
// note_div_lut: maps a 4-bit note index to its 20-bit half-period divisor
module note_div_lut
    import sound_pkg::*;
(
    input  logic [3:0]            idx,
    output logic [NOTE_DIV_W-1:0] div
);

    // pure table lookup, shared by any tone block that needs note divisors
    always_comb div = NOTE_DIVS[idx];

endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: fetches song ROM entries and holds each note for its beat count
module melody_sequencer
    import sound_pkg::*;
#(
    parameter int TICK_DIV = 10_000_000,
    parameter int ADDR_W   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic                  loop,
    output logic [ADDR_W-1:0]     rom_addr,
    output logic                  rom_en,
    input  logic [7:0]            rom_data,
    output logic [NOTE_DIV_W-1:0] note_div,
    output logic [3:0]            note_idx,
    output logic                  note_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

    state_t                  state_q, state_d;
    logic [TICK_W-1:0]       tick_q, tick_d;
    logic [2:0]              beat_q, beat_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    rest_q, rest_d;
    logic [3:0]              idx_q, idx_d;
    logic                    rom_en_q, rom_en_d;
    logic                    note_valid_q, note_valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [NOTE_DIV_W-1:0]   note_div_q, note_div_d;
    logic [NOTE_DIV_W-1:0]   lut_div;
    logic [2:0]              dur;

    assign dur = rom_data[DUR_HI:DUR_LO];

    note_div_lut u_lut (
        .idx (idx_d),
        .div (lut_div)
    );

    // next state and counters: stop beats pause, pause freezes everything
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        rest_d  = rest_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start && !stop) begin
                state_d = FETCH;
                addr_d  = '0;
            end
        end else if (stop) begin
            state_d = IDLE;
            tick_d  = '0;
            beat_d  = '0;
            addr_d  = '0;
            rest_d  = 1'b0;
            idx_d   = '0;
        end else if (!pause) begin
            case (state_q)
                // a paused FETCH may have lost its read strobe, so only move on after one was issued
                FETCH: state_d = rom_en_q ? LOAD : FETCH;
                LOAD: begin
                    if (dur == 3'd0) begin
                        state_d = loop ? FETCH : IDLE;
                        addr_d  = loop ? '0 : addr_q;
                        done_d  = !loop;
                    end else begin
                        state_d = HOLD;
                        rest_d  = rom_data[REST_BIT];
                        idx_d   = rom_data[IDX_HI:IDX_LO];
                        beat_d  = dur;
                        tick_d  = '0;
                    end
                end
                HOLD: begin
                    if (tick_q == TICK_MAX) begin
                        tick_d = '0;
                        beat_d = beat_q - 3'd1;
                        if (beat_q == 3'd1) begin
                            state_d = FETCH;
                            addr_d  = addr_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // registered outputs derived from the upcoming state so they line up with it
    always_comb begin
        rom_en_d     = (state_d == FETCH) && !pause;
        note_valid_d = (state_d == HOLD) && !pause && !rest_d;
        note_div_d   = note_valid_d ? lut_div : '0;
        busy_d       = state_d != IDLE;
    end

    // state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            beat_q       <= '0;
            addr_q       <= '0;
            rest_q       <= 1'b0;
            idx_q        <= '0;
            rom_en_q     <= 1'b0;
            note_valid_q <= 1'b0;
            note_div_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            beat_q       <= beat_d;
            addr_q       <= addr_d;
            rest_q       <= rest_d;
            idx_q        <= idx_d;
            rom_en_q     <= rom_en_d;
            note_valid_q <= note_valid_d;
            note_div_q   <= note_div_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign rom_addr   = addr_q;
    assign rom_en     = rom_en_q;
    assign note_div   = note_div_q;
    assign note_idx   = idx_q;
    assign note_valid = note_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: directed scoreboard bench for melody_sequencer at TICK_DIV=4
module tb_melody_sequencer;

    localparam int S_DIV   = 0;
    localparam int S_VAL   = 1;
    localparam int S_BUSY  = 2;
    localparam int S_DONE  = 3;
    localparam int S_ADDR  = 4;
    localparam int S_EN    = 5;
    localparam int S_IDX   = 6;
    localparam int S_DIV2  = 7;
    localparam int S_BUSY2 = 8;
    localparam int S_ADDR2 = 9;
    localparam int S_EN2   = 10;
    localparam int S_DONE2 = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0, pause = 1'b0, loop = 1'b0;
    logic        start2 = 1'b0, stop2 = 1'b0, pause2 = 1'b0, loop2 = 1'b0;
    logic [5:0]  rom_addr;
    logic        rom_en;
    logic [7:0]  rom_data = '0;
    logic [19:0] note_div;
    logic [3:0]  note_idx;
    logic        note_valid, busy, done;
    logic [1:0]  rom_addr2;
    logic        rom_en2;
    logic [7:0]  rom_data2 = '0;
    logic [19:0] note_div2;
    logic [3:0]  note_idx2;
    logic        note_valid2, busy2, done2;

    logic [7:0]  rom_a [64];
    logic [7:0]  rom_b [4];

    typedef struct {
        int          cyc;
        int          sig;
        logic [19:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   ncmp = 0;
    int   nfail = 0;
    int   cyc = 0;
    int   base;

    always #5 clk = ~clk;

    // song ROMs with one cycle of read latency
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_a[rom_addr];
        if (rom_en2) rom_data2 <= rom_b[rom_addr2];
    end

    melody_sequencer #(.TICK_DIV(4), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .loop(loop),
        .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
        .note_div(note_div), .note_idx(note_idx), .note_valid(note_valid),
        .busy(busy), .done(done)
    );

    melody_sequencer #(.TICK_DIV(4), .ADDR_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .stop(stop2), .pause(pause2), .loop(loop2),
        .rom_addr(rom_addr2), .rom_en(rom_en2), .rom_data(rom_data2),
        .note_div(note_div2), .note_idx(note_idx2), .note_valid(note_valid2),
        .busy(busy2), .done(done2)
    );

    function automatic logic [7:0] ent(bit r, int idx, int dur);
        logic [3:0] i4;
        logic [2:0] d3;
        i4 = 4'(idx);
        d3 = 3'(dur);
        return {r, i4, d3};
    endfunction

    function automatic logic [19:0] observe(int sig);
        case (sig)
            S_DIV:   return note_div;
            S_VAL:   return {19'b0, note_valid};
            S_BUSY:  return {19'b0, busy};
            S_DONE:  return {19'b0, done};
            S_ADDR:  return {14'b0, rom_addr};
            S_EN:    return {19'b0, rom_en};
            S_IDX:   return {16'b0, note_idx};
            S_DIV2:  return note_div2;
            S_BUSY2: return {19'b0, busy2};
            S_ADDR2: return {18'b0, rom_addr2};
            S_EN2:   return {19'b0, rom_en2};
            S_DONE2: return {19'b0, done2};
            default: return 20'hxxxxx;
        endcase
    endfunction

    task automatic expect_at(int c, int sig, logic [19:0] val, string tag);
        sb.push_back('{c, sig, val, tag});
    endtask

    task automatic step();
        logic [19:0] o;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                o = observe(sb[i].sig);
                ncmp++;
                assert (o === sb[i].val) else begin
                    nfail++;
                    $error("FAIL %s @cycle %0d: observed %0d expected %0d", sb[i].tag, cyc, o, sb[i].val);
                end
                sb.delete(i);
            end
        end
    endtask

    task automatic run_until(int c);
        while (cyc < c) step();
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        foreach (rom_a[i]) rom_a[i] = '0;
        foreach (rom_b[i]) rom_b[i] = ent(0, i, 1);

        // reset state
        for (int s = S_DIV; s <= S_IDX; s++) expect_at(2, s, 20'd0, "reset");
        expect_at(2, S_BUSY2, 20'd0, "reset.busy2");
        run_until(2);
        rst = 1'b0;
        run_until(3);

        // single note
        rom_a[0] = ent(0, 7, 2);
        rom_a[1] = ent(0, 0, 0);
        base = cyc;
        for (int k = 1; k <= 14; k++)
            expect_at(base + k, S_DIV, (k >= 3 && k <= 10) ? 20'd153256 : 20'd0, "single.div");
        expect_at(base + 1, S_EN, 20'd1, "single.en1");
        expect_at(base + 2, S_EN, 20'd0, "single.en2");
        expect_at(base + 1, S_BUSY, 20'd1, "single.busy1");
        expect_at(base + 3, S_VAL, 20'd1, "single.valid");
        expect_at(base + 3, S_IDX, 20'd7, "single.idx");
        expect_at(base + 11, S_VAL, 20'd0, "single.gapvalid");
        expect_at(base + 11, S_ADDR, 20'd1, "single.addr");
        expect_at(base + 12, S_BUSY, 20'd1, "single.busy12");
        expect_at(base + 12, S_DONE, 20'd0, "single.done12");
        expect_at(base + 13, S_DONE, 20'd1, "single.done13");
        expect_at(base + 13, S_BUSY, 20'd0, "single.busy13");
        expect_at(base + 14, S_DONE, 20'd0, "single.done14");
        kick();
        run_until(base + 15);

        // rest then note
        rom_a[0] = ent(1, 3, 1);
        rom_a[1] = ent(0, 4, 1);
        rom_a[2] = ent(0, 0, 0);
        base = cyc;
        for (int k = 3; k <= 6; k++) begin
            expect_at(base + k, S_DIV, 20'd0, "rest.div");
            expect_at(base + k, S_VAL, 20'd0, "rest.valid");
            expect_at(base + k, S_BUSY, 20'd1, "rest.busy");
        end
        expect_at(base + 3, S_IDX, 20'd3, "rest.idx");
        for (int k = 9; k <= 12; k++) begin
            expect_at(base + k, S_DIV, 20'd51020, "note.div");
            expect_at(base + k, S_VAL, 20'd1, "note.valid");
        end
        expect_at(base + 9, S_IDX, 20'd4, "note.idx");
        expect_at(base + 15, S_DONE, 20'd1, "rest.done");
        kick();
        run_until(base + 16);

        // pause mid-note
        rom_a[0] = ent(0, 7, 2);
        rom_a[1] = ent(0, 0, 0);
        base = cyc;
        for (int k = 3; k <= 16; k++)
            expect_at(base + k, S_DIV, (k <= 5 || (k >= 11 && k <= 15)) ? 20'd153256 : 20'd0, "pause.div");
        expect_at(base + 8, S_VAL, 20'd0, "pause.valid");
        expect_at(base + 8, S_BUSY, 20'd1, "pause.busy");
        expect_at(base + 17, S_DONE, 20'd0, "pause.done17");
        expect_at(base + 18, S_DONE, 20'd1, "pause.done18");
        expect_at(base + 18, S_BUSY, 20'd0, "pause.busy18");
        kick();
        run_until(base + 5);
        pause = 1'b1;
        run_until(base + 10);
        pause = 1'b0;
        run_until(base + 19);

        // stop mid-note, then start+stop together in idle
        base = cyc;
        expect_at(base + 6, S_DIV, 20'd153256, "stop.before");
        expect_at(base + 7, S_BUSY, 20'd0, "stop.busy");
        expect_at(base + 7, S_DIV, 20'd0, "stop.div");
        expect_at(base + 7, S_VAL, 20'd0, "stop.valid");
        for (int k = 7; k <= 9; k++) expect_at(base + k, S_DONE, 20'd0, "stop.nodone");
        for (int k = 11; k <= 12; k++) begin
            expect_at(base + k, S_BUSY, 20'd0, "startstop.busy");
            expect_at(base + k, S_EN, 20'd0, "startstop.en");
        end
        kick();
        run_until(base + 6);
        stop = 1'b1;
        step();
        stop = 1'b0;
        run_until(base + 10);
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        run_until(base + 13);

        // loop at end marker, and address wrap on a 2-bit ROM
        rom_a[0] = ent(0, 5, 1);
        rom_a[1] = ent(0, 6, 1);
        rom_a[2] = ent(1, 2, 1);
        rom_a[3] = ent(0, 0, 0);
        loop = 1'b1;
        base = cyc;
        for (int k = 1; k <= 26; k++) expect_at(base + k, S_DONE, 20'd0, "loop.nodone");
        expect_at(base + 15, S_DIV, 20'd0, "loop.restdiv");
        expect_at(base + 19, S_ADDR, 20'd3, "loop.addr3");
        expect_at(base + 19, S_EN, 20'd1, "loop.en3");
        expect_at(base + 21, S_ADDR, 20'd0, "loop.addr0");
        expect_at(base + 21, S_EN, 20'd1, "loop.en0");
        expect_at(base + 23, S_DIV, 20'd45454, "loop.div");
        expect_at(base + 3, S_DIV2, 20'd76628, "wrap.div");
        expect_at(base + 19, S_ADDR2, 20'd3, "wrap.addr3");
        expect_at(base + 25, S_ADDR2, 20'd0, "wrap.addr0");
        expect_at(base + 25, S_EN2, 20'd1, "wrap.en0");
        expect_at(base + 26, S_BUSY2, 20'd1, "wrap.busy");
        expect_at(base + 26, S_DONE2, 20'd0, "wrap.nodone");
        expect_at(base + 28, S_BUSY, 20'd0, "loop.stopbusy");
        expect_at(base + 28, S_BUSY2, 20'd0, "wrap.stopbusy");
        start = 1'b1;
        start2 = 1'b1;
        step();
        start = 1'b0;
        start2 = 1'b0;
        run_until(base + 27);
        stop = 1'b1;
        stop2 = 1'b1;
        loop = 1'b0;
        step();
        stop = 1'b0;
        stop2 = 1'b0;
        run_until(base + 29);

        // reset during the second note, then replay from address 0
        rom_a[0] = ent(0, 7, 1);
        rom_a[1] = ent(0, 9, 1);
        rom_a[2] = ent(0, 0, 0);
        base = cyc;
        expect_at(base + 10, S_DIV, 20'd121212, "rstmid.div");
        expect_at(base + 10, S_ADDR, 20'd1, "rstmid.addr");
        expect_at(base + 10, S_IDX, 20'd9, "rstmid.idx");
        for (int s = S_DIV; s <= S_IDX; s++) expect_at(base + 11, s, 20'd0, "rstmid.reset");
        expect_at(base + 14, S_EN, 20'd1, "replay.en");
        expect_at(base + 14, S_ADDR, 20'd0, "replay.addr");
        expect_at(base + 16, S_DIV, 20'd153256, "replay.div");
        expect_at(base + 16, S_IDX, 20'd7, "replay.idx");
        expect_at(base + 22, S_DIV, 20'd121212, "replay.div2");
        expect_at(base + 28, S_DONE, 20'd1, "replay.done");
        kick();
        run_until(base + 10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run_until(base + 13);
        kick();
        run_until(base + 30);

        foreach (sb[i]) begin
            nfail++;
            $error("FAIL %s @cycle %0d: observed never-sampled expected %0d", sb[i].tag, sb[i].cyc, sb[i].val);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
